// File: rtl/ws_array_if.sv
// Control bundle between a weight-stationary systolic array controller and its host.
// The host drives job requests and the stall input; the controller drives the array strobes.
interface ws_array_if #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int VEC_W = 8
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic             start;
  logic [VEC_W-1:0] num_vecs;
  logic             hold;
  logic             busy;
  logic             done;
  logic             mode;
  logic             pe_enable;
  logic             w_load;
  logic [ROW_W-1:0] w_row_sel;
  logic             a_rd;
  logic [VEC_W-1:0] a_addr;
  logic [ROWS-1:0]  a_valid_skew;

  modport master (
    output start, num_vecs, hold,
    input  busy, done, mode, pe_enable, w_load, w_row_sel, a_rd, a_addr, a_valid_skew
  );

  modport slave (
    input  start, num_vecs, hold,
    output busy, done, mode, pe_enable, w_load, w_row_sel, a_rd, a_addr, a_valid_skew
  );
endinterface

// File: rtl/ws_array_controller.sv
// Sequences one weight-stationary job: load ROWS weight rows, stream num_vecs activations,
// drain the array pipeline, then pulse done. hold stalls every active phase in place.
module ws_array_controller #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int VEC_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  ws_array_if.slave   bus
);
  localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DRAIN_LEN = ROWS + COLS - 1;
  localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [VEC_W-1:0]   vecs_q;
  logic [ROW_W-1:0]   row_q;
  logic [VEC_W-1:0]   addr_q;
  logic [DRAIN_W-1:0] drain_q;

  logic row_last;
  logic addr_last;
  logic drain_last;
  logic active;
  logic frozen;
  logic busy;
  logic done;
  logic mode;
  logic pe_enable;
  logic w_load;
  logic a_rd;

  assign row_last   = (row_q == ROW_W'(ROWS - 1));
  // STREAM is only entered with vecs_q >= 1, so the subtraction never underflows there.
  assign addr_last  = (addr_q == vecs_q - VEC_W'(1));
  assign drain_last = (drain_q == DRAIN_W'(DRAIN_LEN - 1));
  assign active     = (state_q == LOAD_W) || (state_q == STREAM) || (state_q == DRAIN);
  assign frozen     = active && bus.hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    mode      = (state_q == STREAM) || (state_q == DRAIN);
    pe_enable = active && !bus.hold;
    w_load    = (state_q == LOAD_W) && !bus.hold;
    a_rd      = (state_q == STREAM) && !bus.hold;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = LOAD_W;
      LOAD_W:  if (!bus.hold && row_last) state_d = (vecs_q == '0) ? DONE : STREAM;
      STREAM:  if (!bus.hold && addr_last) state_d = DRAIN;
      DRAIN:   if (!bus.hold && drain_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vecs_q  <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      drain_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            vecs_q  <= bus.num_vecs;
            row_q   <= '0;
            addr_q  <= '0;
            drain_q <= '0;
          end
        end
        LOAD_W: if (!bus.hold) row_q   <= row_last   ? '0 : row_q + ROW_W'(1);
        STREAM: if (!bus.hold) addr_q  <= addr_last  ? '0 : addr_q + VEC_W'(1);
        DRAIN:  if (!bus.hold) drain_q <= drain_last ? '0 : drain_q + DRAIN_W'(1);
        default: ;
      endcase
    end
  end

  // Row r of the array sees the activation read r cycles late; the chain stalls with the job.
  if (ROWS > 1) begin : g_skew
    logic [ROWS-1:1] chain_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        chain_q <= '0;
      end else if (!frozen) begin
        chain_q[1] <= a_rd;
        for (int r = 2; r < ROWS; r++) chain_q[r] <= chain_q[r-1];
      end
    end

    assign bus.a_valid_skew = {chain_q, a_rd};
  end else begin : g_no_skew
    assign bus.a_valid_skew = a_rd;
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.mode      = mode;
  assign bus.pe_enable = pe_enable;
  assign bus.w_load    = w_load;
  assign bus.w_row_sel = row_q;
  assign bus.a_rd      = a_rd;
  assign bus.a_addr    = addr_q;
endmodule

// File: tb/tb_ws_array_controller.sv
// Scoreboard bench: a slot-based job model predicts every output cycle; a negedge monitor
// pops one prediction per cycle (or expects idle outputs when nothing is queued).
module tb_ws_array_controller;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int VEC_W = 8;
  localparam int RW    = 2;
  localparam int DL    = ROWS + COLS - 1;

  typedef struct {
    bit               busy;
    bit               done;
    bit               chk_mp;
    bit               mode;
    bit               pe_enable;
    bit               w_load;
    bit               chk_row;
    logic [RW-1:0]    row;
    bit               a_rd;
    bit               chk_addr;
    logic [VEC_W-1:0] addr;
    logic [ROWS-1:0]  skew;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ws_array_if #(.ROWS(ROWS), .COLS(COLS), .VEC_W(VEC_W)) bus ();

  ws_array_controller #(.ROWS(ROWS), .COLS(COLS), .VEC_W(VEC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t exp_q[$];
  exp_t trace_q[$];
  bit   hold_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  task automatic check(input bit ok, input string name, input string act, input string req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %s, expected %s (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic string act_str();
    return $sformatf("busy=%b done=%b mode=%b pe=%b wl=%b row=%0d rd=%b addr=%0d skew=%b",
                     bus.busy, bus.done, bus.mode, bus.pe_enable, bus.w_load, bus.w_row_sel,
                     bus.a_rd, bus.a_addr, bus.a_valid_skew);
  endfunction

  function automatic string exp_str(input exp_t e);
    return $sformatf("busy=%b done=%b mode=%b pe=%b wl=%b row=%0d rd=%b addr=%0d skew=%b",
                     e.busy, e.done, e.mode, e.pe_enable, e.w_load, e.row,
                     e.a_rd, e.addr, e.skew);
  endfunction

  // Monitor: one comparison per sampled cycle.
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() > 0) begin
          e  = exp_q.pop_front();
          ok = (bus.busy == e.busy) && (bus.done == e.done) && (bus.w_load == e.w_load) &&
               (bus.a_rd == e.a_rd) && (bus.a_valid_skew == e.skew) &&
               (!e.chk_mp   || (bus.mode == e.mode && bus.pe_enable == e.pe_enable)) &&
               (!e.chk_row  || (bus.w_row_sel == e.row)) &&
               (!e.chk_addr || (bus.a_addr == e.addr));
          check(ok, "job_cycle", act_str(), exp_str(e));
        end else begin
          ok = !bus.busy && !bus.done && !bus.mode && !bus.pe_enable && !bus.w_load &&
               !bus.a_rd && (bus.a_valid_skew == '0);
          check(ok, "idle_cycle", act_str(), "all control outputs 0");
        end
      end
    end
  end

  function automatic bit in_stream(input int slot, input int n);
    return (slot >= ROWS) && (slot < ROWS + n);
  endfunction

  // Reference: a job is a sequence of slots (ROWS loads, n reads, drain, done);
  // every unheld cycle consumes one slot, a held cycle repeats it with strobes off.
  task automatic model_job(input int n, input int hold_pct, input int hf, input int hl);
    int   s;
    int   last;
    bit   h;
    bit   held;
    exp_t e;
    s    = 0;
    last = ROWS + n + ((n == 0) ? 0 : DL);
    trace_q.delete();
    hold_q.delete();
    for (int c = 0; c < 4000; c++) begin
      h    = ($urandom_range(99) < hold_pct) || (c >= hf && c < hf + hl);
      held = h && (s != last);
      e    = '{default: '0};
      e.busy      = 1'b1;
      e.done      = (s == last);
      e.chk_mp    = (s != last);
      e.mode      = (s >= ROWS) && (s < last);
      e.pe_enable = !held;
      if (s < ROWS) begin
        e.chk_row = 1'b1;
        e.row     = RW'(s);
        e.w_load  = !held;
      end else if (s < ROWS + n) begin
        e.chk_addr = 1'b1;
        e.addr     = VEC_W'(s - ROWS);
        e.a_rd     = !held;
      end
      e.skew[0] = e.a_rd;
      for (int k = 1; k < ROWS; k++) e.skew[k] = in_stream(s - k, n);
      trace_q.push_back(e);
      hold_q.push_back(h);
      if (s == last) break;
      if (!held) s++;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    bit ok;
    ok = !bus.busy && !bus.done && !bus.mode && !bus.pe_enable && !bus.w_load &&
         (bus.w_row_sel == '0) && !bus.a_rd && (bus.a_addr == '0) && (bus.a_valid_skew == '0);
    check(ok, name, act_str(), "all outputs 0");
  endtask

  // dup_at: cycle index to re-pulse start; abort_at: cycle index to assert reset.
  task automatic run_job(input int n, input int hold_pct, input int hf, input int hl,
                         input int dup_at, input int abort_at);
    model_job(n, hold_pct, hf, hl);
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.num_vecs = VEC_W'(n);
    bus.hold     = 1'($urandom_range(1));
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.num_vecs = VEC_W'($urandom);
    foreach (trace_q[i]) exp_q.push_back(trace_q[i]);
    for (int c = 0; c < hold_q.size(); c++) begin
      bus.hold  = hold_q[c];
      bus.start = (c == dup_at);
      if (c == abort_at) begin
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_reset_outputs("abort_reset");
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        @(posedge clk); #3;
        reset = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    bus.hold  = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
      @(negedge clk); #1;
    end
    check(exp_q.size() == 0, "job_drained", $sformatf("%0d left", exp_q.size()), "0 left");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.hold     = 1'b0;
    bus.num_vecs = '0;
    #12;
    check_reset_outputs("power_on_reset");
    @(posedge clk); #3;
    reset  = 1'b0;
    mon_en = 1'b1;

    run_job(3, 0, -1, 0, -1, -1);     // basic job, done on 15th cycle
    run_job(0, 0, -1, 0, -1, -1);     // no vectors: load then done
    run_job(3, 0, 5, 2, -1, -1);      // two-cycle hold while a_addr=1
    run_job(2, 0, -1, 0, -1, -1);     // skew chain timing
    run_job(4, 0, -1, 0, 5, -1);      // second start during STREAM
    run_job(3, 0, -1, 0, -1, 9);      // reset in DRAIN
    run_job(3, 0, -1, 0, -1, -1);     // clean job after abort
    for (int j = 0; j < 10; j++) begin
      run_job(int'($urandom_range(12)), 30, -1, 0, int'($urandom_range(20)), -1);
    end
    run_job(255, 10, -1, 0, -1, -1);  // largest vector count

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
